// File: rtl/adder_pkg.sv
// Shared constants and types for the
// adder_12_pipe partition leaf.
package adder_pkg;

  localparam int OPW = 3;
  localparam int SUMW = OPW + 1;

  typedef logic [SUMW-1:0] sum_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used as a link
// in the ripple chain of adder_12_pipe.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/adder_12_pipe.sv
// 3b + 3b + cin ripple adder leaf with
// optional output register and valid flop.
module adder_12_pipe
  import adder_pkg::*;
#(
  parameter int OPW = adder_pkg::OPW,
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic pi6,
  input  logic pi5,
  input  logic pi4,
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  output logic po3,
  output logic po2,
  output logic po1,
  output logic po0,
  output logic out_valid
);

  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic [OPW-1:0] s;
  logic [OPW:0]   c;
  sum_t           sum_c;
  sum_t           sum_o;
  logic           valid_q;

  assign op_a = {pi6, pi5, pi4};
  assign op_b = {pi3, pi2, pi1};
  assign c[0] = pi0;

  for (genvar i = 0; i < OPW; i++) begin : g_fa
    fa_cell u_fa (
      .a  (op_a[i]),
      .b  (op_b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign sum_c = {c[OPW], s};

  if (OUT_REG) begin : g_reg
    sum_t sum_q;

    // load result only on qualified inputs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
      end else if (in_valid) begin
        sum_q <= sum_c;
      end
    end

    assign sum_o = sum_q;
  end else begin : g_comb
    assign sum_o = sum_c;
  end

  // valid strobe trails in_valid by one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
    end
  end

  assign {po3, po2, po1, po0} = sum_o;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_12_pipe.sv
// Directed bench for adder_12_pipe, registered
// and combinational builds side by side.
module tb_adder_12_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [6:0] pi = '0;

  logic [3:0] po_r;
  logic [3:0] po_c;
  logic       ov_r;
  logic       ov_c;

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  logic [3:0] m_po = '0;
  logic       m_valid = 1'b0;

  always #5 clk = ~clk;

  adder_12_pipe #(.OUT_REG(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .pi6       (pi[6]),
    .pi5       (pi[5]),
    .pi4       (pi[4]),
    .pi3       (pi[3]),
    .pi2       (pi[2]),
    .pi1       (pi[1]),
    .pi0       (pi[0]),
    .po3       (po_r[3]),
    .po2       (po_r[2]),
    .po1       (po_r[1]),
    .po0       (po_r[0]),
    .out_valid (ov_r)
  );

  adder_12_pipe #(.OUT_REG(1'b0)) dut_c (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .pi6       (pi[6]),
    .pi5       (pi[5]),
    .pi4       (pi[4]),
    .pi3       (pi[3]),
    .pi2       (pi[2]),
    .pi1       (pi[1]),
    .pi0       (pi[0]),
    .po3       (po_c[3]),
    .po2       (po_c[2]),
    .po1       (po_c[1]),
    .po0       (po_c[0]),
    .out_valid (ov_c)
  );

  function automatic logic [3:0] add(
    input logic [6:0] v
  );
    int s;
    s = int'(v[6:4]) + int'(v[3:1]) + int'(v[0]);
    return s[3:0];
  endfunction

  task automatic check(
    input string name,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b @%0t",
               name, got, exp, $time);
    end
  endtask

  // reference model: result appears one edge after valid input
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_po = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) m_po = add(pi);
    end
  end

  // compare both builds against the model every cycle
  always @(negedge clk) begin
    if (run) begin
      check("po_reg", po_r, m_po);
      check("ov_reg", {3'b0, ov_r}, {3'b0, m_valid});
      check("po_comb", po_c, add(pi));
      check("ov_comb", {3'b0, ov_c}, {3'b0, m_valid});
    end
  end

  task automatic apply(
    input logic v,
    input logic [6:0] p
  );
    in_valid = v;
    pi = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] spot;
    bit has_spot;

    #12;
    check("rst_po", po_r, 4'b0000);
    check("rst_ov", {3'b0, ov_r}, 4'b0000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run = 1'b1;

    for (int i = 0; i < 128; i++) begin
      apply(1'b1, 7'(i));
      has_spot = 1'b1;
      case (i)
        0:       spot = 4'b0000;
        1:       spot = 4'b0001;
        18:      spot = 4'b0010;
        64:      spot = 4'b0100;
        127:     spot = 4'b1111;
        default: begin
          spot = 4'b0000;
          has_spot = 1'b0;
        end
      endcase
      if (has_spot) begin
        check("spot", po_r, spot);
        check("spot_ov", {3'b0, ov_r}, 4'b0001);
      end
    end

    apply(1'b1, 7'b1110001);
    check("max_c", po_r, 4'b1000);
    apply(1'b1, 7'b1111110);
    check("a7b7", po_r, 4'b1110);

    apply(1'b1, 7'b1111111);
    check("gate_a", po_r, 4'b1111);
    apply(1'b0, 7'b0000001);
    check("gate_po", po_r, 4'b1111);
    check("gate_ov", {3'b0, ov_r}, 4'b0000);

    apply(1'b1, 7'b1111111);
    check("pre_rst", po_r, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    check("arst_po", po_r, 4'b0000);
    check("arst_ov", {3'b0, ov_r}, 4'b0000);
    apply(1'b1, 7'b1010101);
    check("rst_pri", po_r, 4'b0000);
    #2;
    rst = 1'b0;
    apply(1'b1, 7'b0100101);
    check("post_rst", po_r, 4'b0101);
    check("post_ov", {3'b0, ov_r}, 4'b0001);

    pi = 7'b0000000;
    #1;
    check("comb_0", po_c, 4'b0000);
    pi = 7'b1011011;
    #1;
    check("comb_1", po_c, 4'b1011);
    check("comb_hold", po_r, 4'b0101);

    apply(1'b0, 7'b0000000);
    apply(1'b0, 7'b0000000);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
